// File: rtl/dat_xfer_sequencer_pkg.sv
// Shared definitions for the SD DAT transfer sequencer: FSM states, error codes and
// default widths.
package dat_xfer_sequencer_pkg;

   localparam int unsigned BLK_W_DEF      = 4;
   localparam int unsigned TO_W_DEF       = 16;
   localparam int unsigned GAP_CYCLES_DEF = 2;

   typedef enum logic [2:0] {
      StIdle,
      StWaitFifo,
      StWaitBlk,
      StGap,
      StDone,
      StError
   } state_t;

   localparam logic [1:0] ERR_ABORT   = 2'b00;
   localparam logic [1:0] ERR_CRC     = 2'b01;
   localparam logic [1:0] ERR_PHYS_TO = 2'b10;
   localparam logic [1:0] ERR_WDOG    = 2'b11;

endpackage

// File: rtl/dat_xfer_sequencer_xfer_watchdog.sv
// Per-block watchdog: counts cycles since the launch strobe, saturating, and flags the
// cycle whose edge brings the count up to the limit. A zero limit never expires.
module dat_xfer_sequencer_xfer_watchdog #(
   parameter int unsigned TO_W = 16
) (
   input  logic            sd_clock,
   input  logic            reset,
   input  logic            clear_in,
   input  logic            enable_in,
   input  logic [TO_W-1:0] limit_in,
   output logic            expired_out
);

   logic [TO_W-1:0] r_count;
   logic [TO_W-1:0] w_count_inc;

   always_comb begin
      w_count_inc = (r_count == '1) ? r_count : r_count + TO_W'(1);
      expired_out = enable_in && (limit_in != '0) && (w_count_inc >= limit_in);
   end

   // Clearing in the launch cycle loads 1 so the count equals edges elapsed since launch.
   always_ff @(posedge sd_clock) begin
      if (reset) begin
         r_count <= '0;
      end else if (clear_in) begin
         r_count <= TO_W'(1);
      end else if (enable_in) begin
         r_count <= w_count_inc;
      end
   end

endmodule

// File: rtl/dat_xfer_sequencer.sv
// Host-side SD DAT sequencer: latches a transfer request, launches dat_phys one block at
// a time, and ends every transfer with exactly one done or error pulse.
module dat_xfer_sequencer
   import dat_xfer_sequencer_pkg::*;
#(
   parameter int unsigned BLK_W      = BLK_W_DEF,
   parameter int unsigned TO_W       = TO_W_DEF,
   parameter int unsigned GAP_CYCLES = GAP_CYCLES_DEF
) (
   input  logic             sd_clock,
   input  logic             reset,
   input  logic             start_in,
   input  logic             abort_in,
   input  logic             write_read_in,
   input  logic             multiple_in,
   input  logic [BLK_W-1:0] blocks_in,
   input  logic [TO_W-1:0]  timeout_in,
   input  logic             fifo_ready_in,
   input  logic             phys_block_done_in,
   input  logic             phys_crc_err_in,
   input  logic             phys_timeout_in,
   output logic             strobe_out,
   output logic             ack_out,
   output logic             idle_out,
   output logic             write_read_out,
   output logic             multiple_out,
   output logic [BLK_W-1:0] blocks_out,
   output logic [TO_W-1:0]  timeout_out,
   output logic [BLK_W-1:0] blocks_left_out,
   output logic             busy_out,
   output logic             done_out,
   output logic             error_out,
   output logic [1:0]       err_code_out
);

   localparam int unsigned      GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

   state_t           r_state;
   logic             r_idle;
   logic             r_busy;
   logic             r_done;
   logic             r_error;
   logic [1:0]       r_err_code;
   logic             r_write_read;
   logic             r_multiple;
   logic [BLK_W-1:0] r_blocks;
   logic [TO_W-1:0]  r_timeout;
   logic [BLK_W-1:0] r_blocks_left;
   logic [GAP_W-1:0] r_gap_cnt;

   logic             w_strobe;
   logic             w_ack;
   logic             w_wdog_expired;
   logic             w_err_hit;
   logic [1:0]       w_err_code;
   logic [BLK_W-1:0] w_count;
   logic [BLK_W-1:0] w_left_dec;

   // Launch and acknowledge are same-cycle handshakes with dat_phys, so they are decoded
   // from the registered state rather than delayed by a flop.
   always_comb begin
      w_strobe   = !reset && (r_state == StWaitFifo) && fifo_ready_in && !abort_in;
      w_ack      = !reset && (r_state == StWaitBlk) && phys_block_done_in && !phys_crc_err_in
                   && !abort_in && !phys_timeout_in;
      w_count    = multiple_in ? blocks_in : BLK_W'(1);
      w_left_dec = (r_blocks_left == '0) ? '0 : r_blocks_left - BLK_W'(1);
   end

   always_comb begin
      w_err_hit  = 1'b0;
      w_err_code = ERR_ABORT;
      unique case (r_state)
         StWaitFifo, StGap: w_err_hit = abort_in;
         StWaitBlk: begin
            if (abort_in) begin
               w_err_hit = 1'b1;
            end else if (phys_timeout_in) begin
               w_err_hit  = 1'b1;
               w_err_code = ERR_PHYS_TO;
            end else if (phys_block_done_in) begin
               w_err_hit  = phys_crc_err_in;
               w_err_code = ERR_CRC;
            end else if (w_wdog_expired) begin
               w_err_hit  = 1'b1;
               w_err_code = ERR_WDOG;
            end
         end
         default: ;
      endcase
   end

   dat_xfer_sequencer_xfer_watchdog #(
      .TO_W (TO_W)
   ) u_watchdog (
      .sd_clock    (sd_clock),
      .reset       (reset),
      .clear_in    (w_strobe),
      .enable_in   (r_state == StWaitBlk),
      .limit_in    (r_timeout),
      .expired_out (w_wdog_expired)
   );

   always_ff @(posedge sd_clock) begin
      if (reset) begin
         r_state       <= StIdle;
         r_idle        <= 1'b1;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_error       <= 1'b0;
         r_err_code    <= ERR_ABORT;
         r_write_read  <= 1'b0;
         r_multiple    <= 1'b0;
         r_blocks      <= '0;
         r_timeout     <= '0;
         r_blocks_left <= '0;
         r_gap_cnt     <= '0;
      end else begin
         r_done  <= 1'b0;
         r_error <= 1'b0;
         if (w_err_hit) begin
            r_state    <= StError;
            r_error    <= 1'b1;
            r_idle     <= 1'b1;
            r_err_code <= w_err_code;
         end else begin
            unique case (r_state)
               StIdle: begin
                  if (start_in) begin
                     r_write_read  <= write_read_in;
                     r_multiple    <= multiple_in;
                     r_blocks      <= blocks_in;
                     r_timeout     <= timeout_in;
                     r_blocks_left <= w_count;
                     r_err_code    <= ERR_ABORT;
                     r_busy        <= 1'b1;
                     if (w_count == '0) begin
                        r_state <= StDone;
                        r_done  <= 1'b1;
                     end else begin
                        r_state <= StWaitFifo;
                        r_idle  <= 1'b0;
                     end
                  end
               end
               StWaitFifo: begin
                  if (w_strobe) begin
                     r_state <= StWaitBlk;
                  end
               end
               StWaitBlk: begin
                  if (w_ack) begin
                     r_blocks_left <= w_left_dec;
                     r_idle        <= 1'b1;
                     if (w_left_dec == '0) begin
                        r_state <= StDone;
                        r_done  <= 1'b1;
                     end else begin
                        r_state   <= StGap;
                        r_gap_cnt <= GAP_LOAD;
                     end
                  end
               end
               StGap: begin
                  if (r_gap_cnt == '0) begin
                     r_state <= StWaitFifo;
                     r_idle  <= 1'b0;
                  end else begin
                     r_gap_cnt <= r_gap_cnt - GAP_W'(1);
                  end
               end
               StDone, StError: begin
                  r_state <= StIdle;
                  r_busy  <= 1'b0;
               end
               default: r_state <= StIdle;
            endcase
         end
      end
   end

   assign strobe_out      = w_strobe;
   assign ack_out         = w_ack;
   assign idle_out        = r_idle;
   assign write_read_out  = r_write_read;
   assign multiple_out    = r_multiple;
   assign blocks_out      = r_blocks;
   assign timeout_out     = r_timeout;
   assign blocks_left_out = r_blocks_left;
   assign busy_out        = r_busy;
   assign done_out        = r_done;
   assign error_out       = r_error;
   assign err_code_out    = r_err_code;

endmodule

// File: tb/tb_dat_xfer_sequencer.sv
// Directed bench for dat_xfer_sequencer: hand-computed expectations for launch latency,
// gaps, stalls, error priority, watchdog timing and reset behaviour.
module tb_dat_xfer_sequencer;

   logic        sd_clock = 1'b0;
   logic        reset = 1'b1;
   logic        start_in = 1'b0;
   logic        abort_in = 1'b0;
   logic        write_read_in = 1'b0;
   logic        multiple_in = 1'b0;
   logic [3:0]  blocks_in = '0;
   logic [15:0] timeout_in = '0;
   logic        fifo_ready_in = 1'b0;
   logic        phys_block_done_in = 1'b0;
   logic        phys_crc_err_in = 1'b0;
   logic        phys_timeout_in = 1'b0;
   logic        strobe_out, ack_out, idle_out, write_read_out, multiple_out;
   logic [3:0]  blocks_out, blocks_left_out;
   logic [15:0] timeout_out;
   logic        busy_out, done_out, error_out;
   logic [1:0]  err_code_out;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int n_strobe, n_ack, n_done, n_err, n_busy_low, last_ack, last_strobe, min_gap;
   logic expect_busy = 1'b0;

   dat_xfer_sequencer u_dut (
      .sd_clock           (sd_clock),
      .reset              (reset),
      .start_in           (start_in),
      .abort_in           (abort_in),
      .write_read_in      (write_read_in),
      .multiple_in        (multiple_in),
      .blocks_in          (blocks_in),
      .timeout_in         (timeout_in),
      .fifo_ready_in      (fifo_ready_in),
      .phys_block_done_in (phys_block_done_in),
      .phys_crc_err_in    (phys_crc_err_in),
      .phys_timeout_in    (phys_timeout_in),
      .strobe_out         (strobe_out),
      .ack_out            (ack_out),
      .idle_out           (idle_out),
      .write_read_out     (write_read_out),
      .multiple_out       (multiple_out),
      .blocks_out         (blocks_out),
      .timeout_out        (timeout_out),
      .blocks_left_out    (blocks_left_out),
      .busy_out           (busy_out),
      .done_out           (done_out),
      .error_out          (error_out),
      .err_code_out       (err_code_out)
   );

   always #5 sd_clock = ~sd_clock;

   always @(posedge sd_clock) cyc <= cyc + 1;

   // Event monitor, sampled mid-cycle.
   always @(negedge sd_clock) begin
      if (strobe_out === 1'b1) begin
         n_strobe    <= n_strobe + 1;
         last_strobe <= cyc;
         if (last_ack >= 0 && (cyc - last_ack) < min_gap) min_gap <= cyc - last_ack;
      end
      if (ack_out === 1'b1) begin
         n_ack    <= n_ack + 1;
         last_ack <= cyc;
      end
      if (done_out === 1'b1) n_done <= n_done + 1;
      if (error_out === 1'b1) n_err <= n_err + 1;
      if (expect_busy && busy_out !== 1'b1) n_busy_low <= n_busy_low + 1;
   end

   initial begin
      #300000;
      $display("FAIL bench_timeout: simulation time limit reached");
      $fatal(1, "bench time limit");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge sd_clock);
      #1;
   endtask

   task automatic clear_mon();
      n_strobe = 0; n_ack = 0; n_done = 0; n_err = 0; n_busy_low = 0;
      last_ack = -1; last_strobe = -1; min_gap = 1000;
   endtask

   task automatic do_start(input logic wr, input logic mult, input logic [3:0] blks,
                           input logic [15:0] to);
      write_read_in = wr; multiple_in = mult; blocks_in = blks; timeout_in = to;
      start_in = 1'b1;
      step();
      start_in = 1'b0;
   endtask

   task automatic wait_strobe(input string tag);
      int k = 0;
      while (strobe_out !== 1'b1 && k < 100) begin
         step();
         k++;
      end
      if (k >= 100) check_eq(tag, strobe_out, 1);
   endtask

   task automatic blk_done(input logic crc, input logic exp_ack, input string tag);
      phys_block_done_in = 1'b1;
      phys_crc_err_in = crc;
      #1;
      check_eq(tag, ack_out, exp_ack);
      step();
      phys_block_done_in = 1'b0;
      phys_crc_err_in = 1'b0;
   endtask

   initial begin
      clear_mon();
      repeat (3) step();
      check_eq("rst_idle", idle_out, 1);
      check_eq("rst_busy", busy_out, 0);
      check_eq("rst_left", blocks_left_out, 0);
      check_eq("rst_pulses", {strobe_out, ack_out, done_out, error_out}, 0);
      check_eq("rst_latched", {write_read_out, multiple_out, blocks_out, timeout_out}, 0);
      reset = 1'b0;
      step();

      // Single read: multiple=0 forces one block.
      clear_mon();
      fifo_ready_in = 1'b1;
      do_start(1'b0, 1'b0, 4'd4, 16'd0);
      check_eq("t1_latency_strobe", strobe_out, 1);
      check_eq("t1_left", blocks_left_out, 1);
      check_eq("t1_blocks_out", blocks_out, 4);
      check_eq("t1_idle_low", idle_out, 0);
      repeat (20) step();
      blk_done(1'b0, 1'b1, "t1_ack");
      check_eq("t1_done", done_out, 1);
      check_eq("t1_left0", blocks_left_out, 0);
      check_eq("t1_busy_in_done", busy_out, 1);
      step();
      check_eq("t1_busy_fall", busy_out, 0);
      check_eq("t1_counts", {n_strobe[7:0], n_ack[7:0], n_done[7:0], n_err[7:0]}, 32'h01010100);

      // Multi write, three blocks with gaps.
      clear_mon();
      do_start(1'b1, 1'b1, 4'd3, 16'd0);
      expect_busy = 1'b1;
      for (int b = 0; b < 3; b++) begin
         wait_strobe("t2_strobe_wait");
         repeat (3) step();
         blk_done(1'b0, 1'b1, "t2_ack");
         if (b < 2) check_eq("t2_gap_idle", idle_out, 1);
      end
      check_eq("t2_done", done_out, 1);
      expect_busy = 1'b0;
      step();
      check_eq("t2_counts", {n_strobe[7:0], n_ack[7:0], n_done[7:0], n_err[7:0]}, 32'h03030100);
      check_eq("t2_min_gap", min_gap, 3);
      check_eq("t2_busy_held", n_busy_low, 0);
      check_eq("t2_latched", {write_read_out, multiple_out}, 2'b11);

      // FIFO stall before block 2; watchdog must not run while stalled.
      clear_mon();
      do_start(1'b1, 1'b1, 4'd2, 16'd10);
      step();
      fifo_ready_in = 1'b0;
      step();
      blk_done(1'b0, 1'b1, "t3_ack1");
      repeat (50) step();
      check_eq("t3_stalled", n_strobe, 1);
      fifo_ready_in = 1'b1;
      #1;
      check_eq("t3_strobe_on_ready", strobe_out, 1);
      step();
      step();
      blk_done(1'b0, 1'b1, "t3_ack2");
      check_eq("t3_done", done_out, 1);
      step();
      check_eq("t3_no_err", n_err, 0);

      // CRC failure on block 2 of 4.
      clear_mon();
      do_start(1'b1, 1'b1, 4'd4, 16'd0);
      step();
      blk_done(1'b0, 1'b1, "t4_ack1");
      wait_strobe("t4_strobe_wait");
      repeat (3) step();
      blk_done(1'b1, 1'b0, "t4_no_ack");
      check_eq("t4_error", error_out, 1);
      check_eq("t4_code", err_code_out, 2'b01);
      check_eq("t4_left", blocks_left_out, 3);
      check_eq("t4_idle", idle_out, 1);
      step();
      check_eq("t4_busy_fall", busy_out, 0);
      check_eq("t4_code_hold", err_code_out, 2'b01);
      check_eq("t4_counts", {n_ack[7:0], n_done[7:0], n_err[7:0]}, 24'h010001);

      // Watchdog expiry at exactly 100 cycles after the strobe.
      clear_mon();
      do_start(1'b0, 1'b0, 4'd1, 16'd100);
      begin
         int k = 0;
         while (error_out !== 1'b1 && k < 200) begin
            step();
            k++;
         end
      end
      check_eq("t5_err_seen", error_out, 1);
      check_eq("t5_err_delay", cyc - last_strobe, 100);
      check_eq("t5_code", err_code_out, 2'b11);
      step();

      // Watchdog disabled, then abort while waiting for the block.
      clear_mon();
      do_start(1'b0, 1'b0, 4'd1, 16'd0);
      repeat (1000) step();
      check_eq("t5b_no_err", n_err, 0);
      check_eq("t5b_busy", busy_out, 1);
      abort_in = 1'b1;
      step();
      abort_in = 1'b0;
      check_eq("t5b_abort_err", error_out, 1);
      check_eq("t5b_abort_code", err_code_out, 2'b00);
      step();

      // Abort and clean block_done together: abort wins.
      clear_mon();
      do_start(1'b0, 1'b0, 4'd1, 16'd0);
      step();
      abort_in = 1'b1;
      blk_done(1'b0, 1'b0, "t6_no_ack");
      abort_in = 1'b0;
      check_eq("t6_error", error_out, 1);
      check_eq("t6_code", err_code_out, 2'b00);
      check_eq("t6_left", blocks_left_out, 1);
      step();

      // Reset while waiting for a block.
      clear_mon();
      do_start(1'b1, 1'b1, 4'd3, 16'd5);
      step();
      reset = 1'b1;
      phys_block_done_in = 1'b1;
      #1;
      check_eq("t7_no_ack_in_reset", ack_out, 0);
      step();
      reset = 1'b0;
      phys_block_done_in = 1'b0;
      check_eq("t7_idle", idle_out, 1);
      check_eq("t7_busy", busy_out, 0);
      check_eq("t7_regs", {write_read_out, multiple_out, blocks_out, timeout_out}, 0);
      check_eq("t7_left", blocks_left_out, 0);
      repeat (3) step();
      check_eq("t7_no_pulses", {n_ack[7:0], n_done[7:0], n_err[7:0]}, 0);

      // Start while busy is ignored; abort in WAIT_FIFO; abort in IDLE ignored.
      clear_mon();
      fifo_ready_in = 1'b0;
      do_start(1'b0, 1'b1, 4'd2, 16'd0);
      step();
      do_start(1'b1, 1'b0, 4'd9, 16'd77);
      check_eq("t8_blocks_kept", blocks_out, 2);
      check_eq("t8_dir_kept", write_read_out, 0);
      check_eq("t8_to_kept", timeout_out, 0);
      abort_in = 1'b1;
      step();
      abort_in = 1'b0;
      check_eq("t8_abort_fifo", {error_out, err_code_out}, 3'b100);
      step();
      abort_in = 1'b1;
      step();
      abort_in = 1'b0;
      check_eq("t8_abort_idle", {error_out, idle_out, busy_out}, 3'b010);

      // Zero block count completes without any strobe.
      clear_mon();
      fifo_ready_in = 1'b1;
      do_start(1'b0, 1'b1, 4'd0, 16'd0);
      check_eq("t9_done", {done_out, busy_out, strobe_out}, 3'b110);
      step();
      check_eq("t9_busy_fall", busy_out, 0);
      check_eq("t9_no_strobe", n_strobe, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/dat_xfer_sequencer.md
Name: dat_xfer_sequencer

Overview:
Host-side sequencer for the SD DAT physical layer (dat_phys). It latches a transfer request from the CMD controller or register block and launches dat_phys one block at a time. It gates each block launch on FIFO readiness, acknowledges each completed block, counts the remaining blocks and enforces a watchdog. It ends every transfer with exactly one done or error indication. It sits between the CMD controller/register file and dat_phys, in the sd_clock domain.

Parameters:
BLK_W, 4, width of block-count fields
TO_W, 16, width of timeout fields
GAP_CYCLES, 2, idle cycles forced between consecutive blocks (min 1)

Ports:
sd_clock  in  1  single clock; all logic on its rising edge
reset  in  1  synchronous, active-high reset
start_in  in  1  one-cycle request; sampled only in IDLE
abort_in  in  1  abort current transfer
write_read_in  in  1  1=host-to-card write, 0=card-to-host read
multiple_in  in  1  1=multi-block; 0 forces one block
blocks_in  in  BLK_W  requested block count
timeout_in  in  TO_W  watchdog limit in sd_clock cycles; 0 disables watchdog
fifo_ready_in  in  1  write: FIFO holds a full block; read: FIFO has room for a block
phys_block_done_in  in  1  dat_phys one-cycle pulse: block finished
phys_crc_err_in  in  1  qualifies phys_block_done_in: CRC/status failure
phys_timeout_in  in  1  dat_phys internal timeout pulse
strobe_out  out  1  one-cycle pulse to dat_phys strobe_in: launch one block
ack_out  out  1  one-cycle pulse to dat_phys ack_in after a good block
idle_out  out  1  level to dat_phys idle_in
write_read_out  out  1  latched direction to dat_phys writeRead
multiple_out  out  1  latched to dat_phys multiple
blocks_out  out  BLK_W  latched count to dat_phys blocks
timeout_out  out  TO_W  latched timeout to dat_phys TIMEOUT_REG
blocks_left_out  out  BLK_W  blocks still to transfer
busy_out  out  1  high from accepted start until done/error cycle inclusive
done_out  out  1  one-cycle pulse: all blocks good
error_out  out  1  one-cycle pulse: transfer terminated
err_code_out  out  2  valid with error_out: 00 abort, 01 CRC, 10 phys timeout, 11 watchdog; holds value until next start

Behaviour:
- Reset (synchronous): state=IDLE; idle_out=1; all other outputs 0; counters 0. Reset mid-transfer drops to IDLE next edge, no done/error pulse.
- States: IDLE, WAIT_FIFO, WAIT_BLK, GAP, DONE, ERROR.
- IDLE: start_in=1 latches write_read/multiple/blocks/timeout outputs. Count = multiple_in ? blocks_in : 1, loaded into blocks_left_out. busy_out=1.
  - Count 0 -> DONE next cycle; no strobe issued.
  - Otherwise -> WAIT_FIFO.
  - start_in outside IDLE is ignored.
- WAIT_FIFO: idle_out=0. When fifo_ready_in=1: strobe_out=1 for that cycle; watchdog cleared -> WAIT_BLK. Stalls indefinitely while not ready; the watchdog does not run here.
- WAIT_BLK: watchdog increments each cycle. Event priority, same cycle:
  1. abort_in -> ERROR, code 00.
  2. phys_timeout_in -> ERROR, code 10.
  3. phys_block_done_in with phys_crc_err_in -> ERROR, code 01.
  4. phys_block_done_in clean -> ack_out=1 that cycle and blocks_left_out decrements. New value 0 -> DONE, else -> GAP.
  5. timeout_in!=0 and watchdog reaches timeout_out -> ERROR, code 11.
- abort_in is also honoured in WAIT_FIFO and GAP (code 00). abort_in in IDLE is ignored.
- GAP: idle_out=1 for exactly GAP_CYCLES cycles -> WAIT_FIFO. Block-to-next-strobe minimum = GAP_CYCLES+1 cycles.
- DONE: done_out=1 one cycle, idle_out=1 -> IDLE.
- ERROR: error_out=1 one cycle, idle_out=1 -> IDLE; blocks_left_out holds value at failure.
- busy_out falls in the cycle after the DONE/ERROR state.
- Watchdog counter is TO_W bits and saturates; it never wraps.
- Down-counter never underflows.
- Latency: start_in -> first strobe_out = 1 cycle when fifo_ready_in is already high.

Decomposition:
- Shared package/definitions include: state encodings, err code constants (ERR_ABORT, ERR_CRC, ERR_PHYS_TO, ERR_WDOG), BLK_W/TO_W defaults.
- One natural sub-module: xfer_watchdog (clear, enable, limit, saturating count, expired flag).
- Block counter and FSM stay in the top module.

Test Plan:
- Single read: start, write_read=0, multiple=0, blocks=4, fifo_ready=1, done pulse 20 cycles after strobe -> one strobe, one ack, blocks_left 1->0, done_out once, err none.
- Multi write, blocks=3, GAP_CYCLES=2 -> three strobes, each ≥3 cycles after the previous ack; three acks; done_out after third; busy_out high throughout.
- FIFO stall: fifo_ready low 50 cycles before block 2, timeout=10 -> no watchdog error; strobe the cycle ready rises.
- CRC failure on block 2 of 4 -> error_out, err_code 01, blocks_left=3, no ack for block 2, idle_out=1.
- Watchdog: timeout=100, no block_done -> error_out exactly 100 cycles after strobe, code 11. Same with timeout=0 for 1000 cycles -> no error.
- Simultaneous abort and block_done -> code 00 wins. Reset mid-WAIT_BLK -> all outputs to reset values, no pulses. start while busy -> ignored. blocks=0 -> done with zero strobes.
